// File: rtl/cbc_pkg.sv
// rtl/cbc_pkg.sv - shared constants, types, state encoding and nibble cipher functions
// Contents: NIB_W/BYTE_W widths, nib_t, state_t, cbc_enc_nib(x,k), cbc_dec_nib(y,k)
package cbc_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 2 * NIB_W;

  typedef logic [NIB_W-1:0] nib_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    ENC_HI,
    ENC_LO,
    HOLD
  } state_t;

  // E(x,k) = rotl1(x ^ k)
  function automatic nib_t cbc_enc_nib(input nib_t x, input nib_t k);
    nib_t t;
    t = x ^ k;
    return {t[NIB_W-2:0], t[NIB_W-1]};
  endfunction

  // D(y,k) = rotr1(y) ^ k
  function automatic nib_t cbc_dec_nib(input nib_t y, input nib_t k);
    return {y[0], y[NIB_W-1:1]} ^ k;
  endfunction

endpackage

// File: rtl/cbc_nib_cipher.sv
// rtl/cbc_nib_cipher.sv - combinational CBC nibble stage y = E(x ^ chain, k)
// Ports: x (plaintext nibble), chain (previous cipher nibble), k (key), y (cipher nibble)
module cbc_nib_cipher
  import cbc_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] chain,
  input  logic [NIB_W-1:0] k,
  output logic [NIB_W-1:0] y
);

  assign y = cbc_enc_nib(x ^ chain, k);

endmodule

// File: rtl/cbc_byte_encryptor.sv
// rtl/cbc_byte_encryptor.sv - streaming CBC byte encryptor, two chained nibble blocks per byte
// Ports: clk, rst_n (sync, active-low); start/k/iv open a message; in_* plaintext
// valid/ready stream; out_* ciphertext valid/ready stream; busy while not idle.
// Build option: CBC_ENC_BYTE_COUNT_EN adds byte_cnt[7:0] (saturating output handshake count).
module cbc_byte_encryptor
  import cbc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NIB_W-1:0]  k,
  input  logic [NIB_W-1:0]  iv,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
`ifdef CBC_ENC_BYTE_COUNT_EN
  output logic              busy,
  output logic [7:0]        byte_cnt
`else
  output logic              busy
`endif
);

  state_t            state_q, state_d;
  nib_t              key_q, key_d;
  nib_t              ch_q, ch_d;
  nib_t              chi_q, chi_d;
  logic [BYTE_W-1:0] pin_q, pin_d;
  logic              last_q, last_d;
  logic [BYTE_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  nib_t cip_x, cip_c, cip_y;

  // One cipher stage serves both halves: ENC_HI chains from ch, ENC_LO from c_hi.
  cbc_nib_cipher u_cipher (
    .x     (cip_x),
    .chain (cip_c),
    .k     (key_q),
    .y     (cip_y)
  );

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    ch_d       = ch_q;
    chi_d      = chi_q;
    pin_d      = pin_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;

    cip_x = (state_q == ENC_LO) ? pin_q[NIB_W-1:0] : pin_q[BYTE_W-1:NIB_W];
    cip_c = (state_q == ENC_LO) ? chi_q : ch_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = k;
          ch_d    = iv;
          state_d = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (in_valid) begin
          pin_d   = in_data;
          last_d  = in_last;
          state_d = ENC_HI;
        end
      end
      ENC_HI: begin
        chi_d   = cip_y;
        state_d = ENC_LO;
      end
      ENC_LO: begin
        ch_d       = cip_y;
        out_data_d = {chi_q, cip_y};
        out_last_d = last_q;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = last_q ? IDLE : WAIT_IN;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    in_ready_d  = (state_d == WAIT_IN);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      ch_q        <= '0;
      chi_q       <= '0;
      pin_q       <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      ch_q        <= ch_d;
      chi_q       <= chi_d;
      pin_q       <= pin_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

`ifdef CBC_ENC_BYTE_COUNT_EN
  logic [7:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (state_q == IDLE && start)
      byte_cnt_d = 8'd0;
    else if (out_valid_q && out_ready && byte_cnt_q != 8'hFF)
      byte_cnt_d = byte_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) byte_cnt_q <= 8'd0;
    else        byte_cnt_q <= byte_cnt_d;
  end

  assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_cbc_byte_encryptor.sv
// tb/tb_cbc_byte_encryptor.sv - self-checking bench for cbc_byte_encryptor
module tb_cbc_byte_encryptor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] k, iv;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic       busy;
`ifdef CBC_ENC_BYTE_COUNT_EN
  logic [7:0] byte_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cbc_byte_encryptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k         (k),
    .iv        (iv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef CBC_ENC_BYTE_COUNT_EN
    .busy      (busy),
    .byte_cnt  (byte_cnt)
`else
    .busy      (busy)
`endif
  );

  typedef struct {
    bit         st;
    logic [3:0] vk;
    logic [3:0] viv;
    logic [7:0] d;
    bit         l;
    logic [7:0] e;
    int         hold;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Independent reference: decrypt nibble D(y,k) = rotr1(y) ^ k
  function automatic logic [3:0] ref_dec(input logic [3:0] y, input logic [3:0] kk);
    return {y[0], y[3:1]} ^ kk;
  endfunction

  // Called at a negedge while IDLE.
  task automatic do_start(input logic [3:0] kk, input logic [3:0] ivv);
    start = 1'b1; k = kk; iv = ivv;
    @(negedge clk);
    start = 1'b0; k = 4'h0; iv = 4'h0;
    chk("start_rdy", in_ready, 1);
  endtask

  // Called at a negedge; returns after the output handshake edge, at a negedge.
  task automatic send_byte(input logic [7:0] d, input bit l, input int hold,
                           output logic [7:0] got, output logic gl);
    int n;
    in_data = d; in_last = l; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 0, 1);
    @(negedge clk);              // acceptance edge N passed
    in_valid = 1'b0;
    chk("lat_n1_valid", out_valid, 0);
    chk("enc_in_ready", in_ready, 0);
    @(negedge clk);              // edge N+1
    chk("lat_n2_valid", out_valid, 0);
    @(negedge clk);              // edge N+2
    chk("lat_n3_valid", out_valid, 1);
    got = out_data;
    gl  = out_last;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, got);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    logic       gl;
    logic [3:0] rk, riv, prev;
    logic [7:0] pt[16];
    logic [7:0] ct[16];

    vt[0] = '{1, 4'hB, 4'h9, 8'h00, 0, 8'h4F, 3};
    vt[1] = '{0, 4'h0, 4'h0, 8'hA5, 1, 8'hD6, 0};
    vt[2] = '{1, 4'h0, 4'h0, 8'h12, 1, 8'h20, 0};
    vt[3] = '{1, 4'hF, 4'h0, 8'h00, 1, 8'hF0, 1};
    vt[4] = '{1, 4'h5, 4'h3, 8'hC7, 1, 8'h5E, 0};
    vt[5] = '{1, 4'h1, 4'h8, 8'hFF, 1, 8'hC4, 0};

    rst_n = 1'b0; start = 1'b0; k = 4'h0; iv = 4'h0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);

    // Reset asserted while the low nibble is being encrypted.
    do_start(4'hB, 4'h9);
    in_data = 8'h00; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);              // accepted, now ENC_HI
    in_valid = 1'b0;
    @(negedge clk);              // now ENC_LO
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_data", out_data, 8'h00);
    chk("midrst_out_last", out_last, 0);
    @(negedge clk);
    chk("midrst_stays_idle", busy, 0);

    // Table of messages; vt[0..1] is a chained two-byte message.
    for (int i = 0; i < 6; i++) begin
      if (vt[i].st) do_start(vt[i].vk, vt[i].viv);
      send_byte(vt[i].d, vt[i].l, vt[i].hold, got, gl);
      chk($sformatf("vec%0d_data", i), got, vt[i].e);
      chk($sformatf("vec%0d_last", i), gl, vt[i].l);
      if (vt[i].l) begin
        chk($sformatf("vec%0d_idle", i), busy, 0);
        chk($sformatf("vec%0d_rdy_idle", i), in_ready, 0);
      end else begin
        chk($sformatf("vec%0d_rdy_next", i), in_ready, 1);
      end
    end

    // Restart with same iv, then a start pulse mid-message must be ignored.
    do_start(4'hB, 4'h9);
    send_byte(8'h00, 0, 0, got, gl);
    chk("restart_data", got, 8'h4F);
    start = 1'b1; k = 4'h0; iv = 4'h0;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_busy", busy, 1);
    send_byte(8'hA5, 1, 0, got, gl);
    chk("midstart_chain_data", got, 8'hD6);
    chk("midstart_last", gl, 1);

    // Round trip through an independent CBC decryptor model.
    rk  = 4'($urandom_range(0, 15));
    riv = 4'($urandom_range(0, 15));
    do_start(rk, riv);
    for (int i = 0; i < 16; i++) begin
      pt[i] = 8'($urandom_range(0, 255));
      send_byte(pt[i], (i == 15), 0, got, gl);
      ct[i] = got;
    end
    chk("rt_last", gl, 1);
    prev = riv;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] c_hi, c_lo;
      logic [7:0] p;
      c_hi = ct[i][7:4];
      c_lo = ct[i][3:0];
      p = {ref_dec(c_hi, rk) ^ prev, ref_dec(c_lo, rk) ^ c_hi};
      chk($sformatf("rt_byte%0d", i), p, pt[i]);
      prev = c_lo;
    end
`ifdef CBC_ENC_BYTE_COUNT_EN
    chk("byte_cnt", byte_cnt, 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
